// File: rtl/pipeline_mem_stage_hs_if.sv
// Data-memory request/grant/response bus used by the MEM stage.
// master = pipeline stage (issues requests), slave = memory (grants, returns data).
interface pipeline_mem_stage_hs_if #(
    parameter int XLEN = 64
);
    localparam int SW = XLEN / 8;

    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [SW-1:0]   dm_wstrb;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/pipeline_mem_stage_hs.sv
// Memory-access pipeline stage with a request/grant/response data-memory
// handshake. Handles byte/half/word/double sizing, store lane steering,
// load extraction with sign/zero extension and misalignment/illegal-size
// detection. EX is stalled via ex_ready while a transaction is in flight;
// WB sees exactly one valid_MEM pulse per accepted instruction.
module pipeline_mem_stage_hs #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    // EX side
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              mem_read_EX,
    input  logic              mem_write_EX,
    input  logic [2:0]        funct3_EX,
    input  logic [XLEN-1:0]   alu_result_EX,
    input  logic [XLEN-1:0]   reg_data2_EX,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic [XLEN-1:0]   pc_EX,
    // data-memory bus
    pipeline_mem_stage_hs_if.master dm,
    // WB side
    output logic              valid_MEM,
    output logic [XLEN-1:0]   mem_data_MEM,
    output logic [XLEN-1:0]   alu_result_MEM,
    output logic [REG_AW-1:0] rd_MEM,
    output logic [XLEN-1:0]   pc_MEM,
    output logic              mem_read_done_MEM,
    output logic              misalign_MEM
);
    localparam int SW   = XLEN / 8;
    localparam int OFFW = $clog2(SW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // EX-side decode (combinational, used only on the acceptance cycle)
    // ------------------------------------------------------------------
    logic            is_mem_ex;
    logic [1:0]      size_ex;
    logic [OFFW-1:0] off_ex;
    logic [OFFW-1:0] align_mask;
    logic [SW-1:0]   strb_base;
    logic            illegal_ex;
    logic            misalign_ex;
    logic            bad_ex;
    logic            accept;
    logic            start_mem;

    assign is_mem_ex = mem_read_EX | mem_write_EX;
    assign size_ex   = funct3_EX[1:0];
    assign off_ex    = alu_result_EX[OFFW-1:0];

    // Offset bits that must be zero for the access size (bits below log2(bytes)).
    // Byte strobe pattern for the access size before lane shifting.
    generate
        for (genvar gi = 0; gi < OFFW; gi++) begin : g_align
            assign align_mask[gi] = (gi < int'(size_ex));
        end
        for (genvar gi = 0; gi < SW; gi++) begin : g_strb
            assign strb_base[gi] = (gi < (1 << size_ex));
        end
    endgenerate

    // Illegal size codes: 111 always, unsigned/upper codes on stores, and
    // the doubleword / unsigned-word codes when the datapath is only 32 bits.
    always_comb begin
        illegal_ex = (funct3_EX == 3'b111) || (mem_write_EX && funct3_EX[2]);
        if (XLEN == 32 && (funct3_EX[1:0] == 2'b11 || funct3_EX == 3'b110)) begin
            illegal_ex = 1'b1;
        end
    end

    assign misalign_ex = |(off_ex & align_mask);
    assign bad_ex      = is_mem_ex && (illegal_ex || misalign_ex);
    assign ex_ready    = (state_reg == IDLE);
    assign accept      = ex_valid && ex_ready;
    assign start_mem   = accept && is_mem_ex && !bad_ex;

    // ------------------------------------------------------------------
    // Captured instruction fields and registered bus outputs
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] rd_reg;
    logic [XLEN-1:0]   alu_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [OFFW-1:0]   off_reg;
    logic              dm_req_reg;
    logic              dm_we_reg;
    logic [XLEN-1:0]   dm_addr_reg;
    logic [XLEN-1:0]   dm_wdata_reg;
    logic [SW-1:0]     dm_wstrb_reg;

    assign dm.dm_req   = dm_req_reg;
    assign dm.dm_we    = dm_we_reg;
    assign dm.dm_addr  = dm_addr_reg;
    assign dm.dm_wdata = dm_wdata_reg;
    assign dm.dm_wstrb = dm_wstrb_reg;

    // ------------------------------------------------------------------
    // Load data extraction: shift the addressed lane down, then extend
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rdata_shifted;
    logic            sign_bit;
    logic [XLEN-1:0] load_ext;

    assign rdata_shifted = dm.dm_rdata >> {off_reg, 3'b000};

    // Top bit of the loaded field, which drives sign extension.
    always_comb begin
        sign_bit = 1'b0;
        case (size_reg)
            2'd0:    sign_bit = rdata_shifted[7];
            2'd1:    sign_bit = rdata_shifted[15];
            2'd2:    sign_bit = rdata_shifted[31];
            default: sign_bit = rdata_shifted[XLEN-1];
        endcase
    end

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
            assign load_ext[gi] = (gi < (8 << size_reg)) ? rdata_shifted[gi]
                                                         : (!uns_reg && sign_bit);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: stores finish on grant, loads wait for read data.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_mem) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dm.dm_gnt) begin
                    state_next = dm_we_reg ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dm.dm_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture EX fields at acceptance and drive the memory request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_reg       <= '0;
            alu_reg      <= '0;
            pc_reg       <= '0;
            size_reg     <= '0;
            uns_reg      <= 1'b0;
            off_reg      <= '0;
            dm_req_reg   <= 1'b0;
            dm_we_reg    <= 1'b0;
            dm_addr_reg  <= '0;
            dm_wdata_reg <= '0;
            dm_wstrb_reg <= '0;
        end else begin
            if (accept) begin
                rd_reg   <= rd_EX;
                alu_reg  <= alu_result_EX;
                pc_reg   <= pc_EX;
                size_reg <= size_ex;
                uns_reg  <= funct3_EX[2];
                off_reg  <= off_ex;
            end
            if (start_mem) begin
                dm_req_reg   <= 1'b1;
                dm_we_reg    <= mem_write_EX;
                dm_addr_reg  <= {alu_result_EX[XLEN-1:OFFW], {OFFW{1'b0}}};
                dm_wdata_reg <= reg_data2_EX << {off_ex, 3'b000};
                dm_wstrb_reg <= strb_base << off_ex;
            end else if (state_reg == REQ && dm.dm_gnt) begin
                dm_req_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered WB-facing output stage
    // ------------------------------------------------------------------
    logic              valid_reg;
    logic [XLEN-1:0]   mem_data_reg;
    logic [XLEN-1:0]   alu_out_reg;
    logic [REG_AW-1:0] rd_out_reg;
    logic [XLEN-1:0]   pc_out_reg;
    logic              done_reg;
    logic              misalign_reg;

    assign valid_MEM         = valid_reg;
    assign mem_data_MEM      = mem_data_reg;
    assign alu_result_MEM    = alu_out_reg;
    assign rd_MEM            = rd_out_reg;
    assign pc_MEM            = pc_out_reg;
    assign mem_read_done_MEM = done_reg;
    assign misalign_MEM      = misalign_reg;

    // Completion pulse with result fields; data fields hold between completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            mem_data_reg <= '0;
            alu_out_reg  <= '0;
            rd_out_reg   <= '0;
            pc_out_reg   <= '0;
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            if (accept && (!is_mem_ex || bad_ex)) begin
                // Non-memory op, or a faulting access that never reaches the bus.
                valid_reg    <= 1'b1;
                rd_out_reg   <= bad_ex ? '0 : rd_EX;
                alu_out_reg  <= alu_result_EX;
                pc_out_reg   <= pc_EX;
                misalign_reg <= bad_ex;
            end else if (state_reg == REQ && dm.dm_gnt && dm_we_reg) begin
                valid_reg    <= 1'b1;
                rd_out_reg   <= rd_reg;
                alu_out_reg  <= alu_reg;
                pc_out_reg   <= pc_reg;
                misalign_reg <= 1'b0;
            end else if (state_reg == WAIT && dm.dm_rvalid) begin
                valid_reg    <= 1'b1;
                done_reg     <= 1'b1;
                mem_data_reg <= load_ext;
                rd_out_reg   <= rd_reg;
                alu_out_reg  <= alu_reg;
                pc_out_reg   <= pc_reg;
                misalign_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage_hs.sv
// Self-checking bench for pipeline_mem_stage_hs: directed cases plus random
// instructions checked against a transaction-level reference model.
module tb_pipeline_mem_stage_hs;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- XLEN=64 instance ----------------
    logic        ex_valid, ex_ready, mem_read_EX, mem_write_EX;
    logic [2:0]  funct3_EX;
    logic [63:0] alu_result_EX, reg_data2_EX, pc_EX;
    logic [4:0]  rd_EX;
    logic        valid_MEM, mem_read_done_MEM, misalign_MEM;
    logic [63:0] mem_data_MEM, alu_result_MEM, pc_MEM;
    logic [4:0]  rd_MEM;

    pipeline_mem_stage_hs_if #(.XLEN(64)) dmif ();

    pipeline_mem_stage_hs #(.XLEN(64), .REG_AW(5)) u_dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX),
        .funct3_EX(funct3_EX), .alu_result_EX(alu_result_EX),
        .reg_data2_EX(reg_data2_EX), .rd_EX(rd_EX), .pc_EX(pc_EX),
        .dm(dmif.master),
        .valid_MEM(valid_MEM), .mem_data_MEM(mem_data_MEM),
        .alu_result_MEM(alu_result_MEM), .rd_MEM(rd_MEM), .pc_MEM(pc_MEM),
        .mem_read_done_MEM(mem_read_done_MEM), .misalign_MEM(misalign_MEM)
    );

    // ---------------- XLEN=32 instance ----------------
    logic        ex_valid_32, ex_ready_32, mem_read_32, mem_write_32;
    logic [2:0]  funct3_32;
    logic [31:0] alu_32, data2_32, pc_32;
    logic [4:0]  rd_32;
    logic        valid_32, done_32, misalign_32;
    logic [31:0] mem_data_out_32, alu_out_32, pc_out_32;
    logic [4:0]  rd_out_32;

    pipeline_mem_stage_hs_if #(.XLEN(32)) dmif32 ();

    pipeline_mem_stage_hs #(.XLEN(32), .REG_AW(5)) u_dut32 (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid_32), .ex_ready(ex_ready_32),
        .mem_read_EX(mem_read_32), .mem_write_EX(mem_write_32),
        .funct3_EX(funct3_32), .alu_result_EX(alu_32),
        .reg_data2_EX(data2_32), .rd_EX(rd_32), .pc_EX(pc_32),
        .dm(dmif32.master),
        .valid_MEM(valid_32), .mem_data_MEM(mem_data_out_32),
        .alu_result_MEM(alu_out_32), .rd_MEM(rd_out_32), .pc_MEM(pc_out_32),
        .mem_read_done_MEM(done_32), .misalign_MEM(misalign_32)
    );

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit model_bad(input bit rd, input bit wr, input logic [2:0] f,
                                     input logic [63:0] a, input int xlen);
        if (!(rd || wr)) return 1'b0;
        if (f == 3'd7) return 1'b1;
        if (wr && f > 3'd3) return 1'b1;
        if (xlen == 32 && (f == 3'd3 || f == 3'd6)) return 1'b1;
        return (a % acc_bytes(f)) != 0;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] f,
                                               input logic [63:0] a);
        int n;
        logic [63:0] v, mask;
        n = acc_bytes(f);
        v = rdata >> (8 * (a % 8));
        if (n < 8) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            v = v & mask;
            if (!f[2] && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input logic [2:0] f, input logic [63:0] a);
        logic [15:0] s;
        s = ((16'd1 << acc_bytes(f)) - 16'd1) << (a % 8);
        return s[7:0];
    endfunction

    // Issue one instruction on the 64-bit DUT and check its whole transaction.
    task automatic run_instr(input bit rd, input bit wr, input logic [2:0] f,
                             input logic [63:0] a, input logic [63:0] data,
                             input logic [4:0] rdi, input bit fix_rdata,
                             input logic [63:0] rdata_in, input int gnt_delay,
                             input int rv_delay);
        bit bad;
        int t;
        logic [63:0] pc, rdata, exp_v;
        bad = model_bad(rd, wr, f, a, 64);
        pc = {32'h0, $urandom} & ~64'h3;
        exp_v = 64'h0;
        t = 0;
        while (ex_ready !== 1'b1 && t < 20) begin
            @(posedge clk) #1;
            t++;
        end
        check_eq("ex_ready_before_issue", ex_ready, 1);
        ex_valid = 1; mem_read_EX = rd; mem_write_EX = wr; funct3_EX = f;
        alu_result_EX = a; reg_data2_EX = data; rd_EX = rdi; pc_EX = pc;
        @(posedge clk) #1;
        ex_valid = 0; mem_read_EX = 0; mem_write_EX = 0;
        alu_result_EX = {$urandom, $urandom}; rd_EX = 5'($urandom);
        if (!(rd || wr) || bad) begin
            check_eq("direct_valid", valid_MEM, 1);
            check_eq("direct_rd", rd_MEM, bad ? 64'd0 : 64'(rdi));
            check_eq("direct_alu", alu_result_MEM, a);
            check_eq("direct_pc", pc_MEM, pc);
            check_eq("direct_misalign", misalign_MEM, bad);
            check_eq("direct_done", mem_read_done_MEM, 0);
            check_eq("direct_no_req", dmif.dm_req, 0);
        end else begin
            check_eq("req_asserted", dmif.dm_req, 1);
            check_eq("req_we", dmif.dm_we, wr);
            check_eq("req_addr", dmif.dm_addr, a & ~64'h7);
            check_eq("req_wstrb", dmif.dm_wstrb, model_strb(f, a));
            if (wr) check_eq("req_wdata", dmif.dm_wdata, data << (8 * (a % 8)));
            check_eq("req_stall", ex_ready, 0);
            check_eq("req_no_valid", valid_MEM, 0);
            for (int d = 0; d < gnt_delay; d++) begin
                dmif.dm_gnt = 0;
                dmif.dm_rvalid = 1'($urandom);
                @(posedge clk) #1;
                check_eq("hold_req", dmif.dm_req, 1);
                check_eq("hold_stall", ex_ready, 0);
                check_eq("hold_no_valid", valid_MEM, 0);
                check_eq("hold_addr", dmif.dm_addr, a & ~64'h7);
            end
            dmif.dm_rvalid = 0;
            dmif.dm_gnt = 1;
            @(posedge clk) #1;
            dmif.dm_gnt = 0;
            if (wr) begin
                check_eq("st_valid", valid_MEM, 1);
                check_eq("st_rd", rd_MEM, rdi);
                check_eq("st_alu", alu_result_MEM, a);
                check_eq("st_pc", pc_MEM, pc);
                check_eq("st_misalign", misalign_MEM, 0);
                check_eq("st_done", mem_read_done_MEM, 0);
                check_eq("st_req_drop", dmif.dm_req, 0);
            end else begin
                check_eq("ld_req_drop", dmif.dm_req, 0);
                check_eq("ld_wait_no_valid", valid_MEM, 0);
                check_eq("ld_wait_stall", ex_ready, 0);
                for (int d = 0; d < rv_delay; d++) begin
                    @(posedge clk) #1;
                    check_eq("ld_wait_no_valid", valid_MEM, 0);
                end
                rdata = fix_rdata ? rdata_in : {$urandom, $urandom};
                dmif.dm_rdata = rdata;
                dmif.dm_rvalid = 1;
                @(posedge clk) #1;
                dmif.dm_rvalid = 0;
                exp_v = model_load(rdata, f, a);
                check_eq("ld_valid", valid_MEM, 1);
                check_eq("ld_done", mem_read_done_MEM, 1);
                check_eq("ld_data", mem_data_MEM, exp_v);
                check_eq("ld_rd", rd_MEM, rdi);
                check_eq("ld_alu", alu_result_MEM, a);
                check_eq("ld_misalign", misalign_MEM, 0);
            end
        end
        $display("TXN rd=%0d wr=%0d f3=%0d addr=%h bad=%0d exp_load=%h", rd, wr, f, a, bad, exp_v);
        @(posedge clk) #1;
        check_eq("gap_no_valid", valid_MEM, 0);
        check_eq("gap_no_done", mem_read_done_MEM, 0);
    endtask

    // Watchdog: every wait above is bounded, this is a last resort.
    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit rd, wr;
        logic [2:0] f;
        logic [63:0] a;
        int k;

        reset = 1;
        ex_valid = 0; mem_read_EX = 0; mem_write_EX = 0; funct3_EX = 0;
        alu_result_EX = 0; reg_data2_EX = 0; rd_EX = 0; pc_EX = 0;
        dmif.dm_gnt = 0; dmif.dm_rvalid = 0; dmif.dm_rdata = 0;
        ex_valid_32 = 0; mem_read_32 = 0; mem_write_32 = 0; funct3_32 = 0;
        alu_32 = 0; data2_32 = 0; rd_32 = 0; pc_32 = 0;
        dmif32.dm_gnt = 0; dmif32.dm_rvalid = 0; dmif32.dm_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", ex_ready, 1);
        check_eq("rst_valid", valid_MEM, 0);
        check_eq("rst_req", dmif.dm_req, 0);
        check_eq("rst_rd", rd_MEM, 0);
        check_eq("rst_data", mem_data_MEM, 0);
        check_eq("rst_misalign", misalign_MEM, 0);
        reset = 0;
        @(posedge clk) #1;

        // Directed cases.
        run_instr(0, 0, 3'd0, 64'h1234, 64'h0, 5'd5, 0, 64'h0, 0, 0);
        run_instr(0, 1, 3'd0, 64'h1003, 64'hAB, 5'd7, 0, 64'h0, 3, 0);
        run_instr(1, 0, 3'd0, 64'h2006, 64'h0, 5'd9, 1, 64'h0080_0000_0000_0000, 0, 0);
        run_instr(1, 0, 3'd4, 64'h2006, 64'h0, 5'd9, 1, 64'h0080_0000_0000_0000, 1, 2);
        run_instr(1, 0, 3'd2, 64'h2002, 64'h0, 5'd3, 0, 64'h0, 0, 0);
        run_instr(1, 0, 3'd7, 64'h2000, 64'h0, 5'd4, 0, 64'h0, 0, 0);
        run_instr(0, 1, 3'd3, 64'h3008, 64'h1122_3344_5566_7788, 5'd6, 0, 64'h0, 0, 0);
        run_instr(1, 0, 3'd1, 64'h400E, 64'h0, 5'd8, 1, 64'h8001_0000_0000_0000, 0, 0);

        // Reset abandoning a load, once while in REQ and once while in WAIT.
        for (int ph = 0; ph < 2; ph++) begin
            ex_valid = 1; mem_read_EX = 1; funct3_EX = 3'd3; alu_result_EX = 64'h2000;
            rd_EX = 5'd11;
            @(posedge clk) #1;
            ex_valid = 0; mem_read_EX = 0;
            if (ph == 1) begin
                dmif.dm_gnt = 1;
                @(posedge clk) #1;
                dmif.dm_gnt = 0;
            end
            #2 reset = 1;
            #1;
            check_eq("abort_req_drop", dmif.dm_req, 0);
            check_eq("abort_ready", ex_ready, 1);
            check_eq("abort_no_valid", valid_MEM, 0);
            dmif.dm_rvalid = 1;
            @(posedge clk) #1;
            reset = 0;
            dmif.dm_rvalid = 0;
            repeat (2) begin
                @(posedge clk) #1;
                check_eq("abort_still_no_valid", valid_MEM, 0);
                check_eq("abort_idle", ex_ready, 1);
            end
        end
        run_instr(1, 0, 3'd3, 64'h8, 64'h0, 5'd12, 1, 64'hDEAD_BEEF_CAFE_F00D, 1, 1);

        // XLEN=32: doubleword and unsigned-word codes are illegal.
        for (int i = 0; i < 2; i++) begin
            ex_valid_32 = 1; mem_read_32 = 1; funct3_32 = (i == 0) ? 3'd3 : 3'd6;
            alu_32 = 32'h8; rd_32 = 5'd13; pc_32 = 32'h100;
            @(posedge clk) #1;
            ex_valid_32 = 0; mem_read_32 = 0;
            check_eq("x32_valid", valid_32, 1);
            check_eq("x32_misalign", misalign_32, 1);
            check_eq("x32_rd", rd_out_32, 0);
            check_eq("x32_no_req", dmif32.dm_req, 0);
            check_eq("x32_done", done_32, 0);
            $display("TXN x32 f3=%0d addr=%h flagged", funct3_32, alu_32);
            @(posedge clk) #1;
        end

        // Randomized instructions.
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(2, 0);
            rd = (k == 1);
            wr = (k == 2);
            if (wr) f = ($urandom_range(7, 0) == 0) ? 3'(4 + $urandom_range(3, 0))
                                                   : 3'($urandom_range(3, 0));
            else f = 3'($urandom_range(7, 0));
            a = {$urandom, $urandom};
            if ($urandom_range(3, 0) != 0) a = a & ~(64'(acc_bytes(f)) - 64'd1);
            run_instr(rd, wr, f, a, {$urandom, $urandom}, 5'($urandom), 0, 64'h0,
                      $urandom_range(3, 0), $urandom_range(3, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
